// File: rtl/ppm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppm_pkg
// Description : Shared types and constants for the ping-pong counter monitor.
//               Monitor state encoding, first-error codes and the event
//               classes a checked transition can fall into.
// Revision    : 1.0 - initial release
// ============================================================================
package ppm_pkg;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,     // no previous sample held
        S_TRACK = 2'd1,     // checking every transition
        S_ERR   = 2'd2      // error latched, counts frozen
    } ppm_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_STEP  = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_DIR   = 2'b11;

    typedef enum logic [2:0] {
        EV_NONE   = 3'd0,
        EV_STEP   = 3'd1,
        EV_BOUNCE = 3'd2,
        EV_FLIP   = 3'd3,
        EV_HOLD   = 3'd4
    } ppm_event_t;

endpackage
`default_nettype wire

// File: rtl/ppm_next_calc.sv
`default_nettype none
// ============================================================================
// Module      : ppm_next_calc
// Description : Combinational successor calculator. From the previous sample
//               (value p, direction d) and the controls in effect it gives the
//               normal next value/direction, the flip next value/direction and
//               the hold / at-bound / strictly-inside flags.
// Ports       : i_prev_out, i_prev_dir, i_prev_en, i_prev_max, i_prev_min in;
//               o_nrm_val/o_nrm_dir, o_flip_val/o_flip_dir, o_hold,
//               o_at_bound, o_inside out.
// Revision    : 1.0 - initial release
// ============================================================================
module ppm_next_calc
    import ppm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_prev_out,
    input  logic             i_prev_dir,
    input  logic             i_prev_en,
    input  logic [WIDTH-1:0] i_prev_max,
    input  logic [WIDTH-1:0] i_prev_min,
    output logic [WIDTH:0]   o_nrm_val,
    output logic             o_nrm_dir,
    output logic [WIDTH:0]   o_flip_val,
    output logic             o_flip_dir,
    output logic             o_hold,
    output logic             o_at_bound,
    output logic             o_inside
);

    localparam logic [WIDTH:0] c_one = (WIDTH+1)'(1);

    // One extra bit so p+1 never wraps to 0; p-1 from 0 lands on a value
    // with the top bit set, which can never equal a zero-extended sample.
    logic [WIDTH:0] w_p;
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;

    assign w_p   = {1'b0, i_prev_out};
    assign w_inc = w_p + c_one;
    assign w_dec = w_p - c_one;

    assign o_hold   = !i_prev_en || (i_prev_max <= i_prev_min) ||
                      (i_prev_out < i_prev_min) || (i_prev_out > i_prev_max);
    assign o_inside = (i_prev_out > i_prev_min) && (i_prev_out < i_prev_max);
    assign o_at_bound = i_prev_dir ? (i_prev_out >= i_prev_max)
                                   : (i_prev_out <= i_prev_min);

    always_comb begin
        o_nrm_val = w_inc;
        o_nrm_dir = 1'b1;
        if (i_prev_dir) begin
            o_nrm_val = o_at_bound ? w_dec : w_inc;
            o_nrm_dir = !o_at_bound;
        end else begin
            o_nrm_val = o_at_bound ? w_inc : w_dec;
            o_nrm_dir = o_at_bound;
        end
    end

    // A flip reverses direction and moves one step the new way.
    assign o_flip_val = i_prev_dir ? w_dec : w_inc;
    assign o_flip_dir = !i_prev_dir;

endmodule
`default_nettype wire

// File: rtl/ping_pong_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ping_pong_monitor
// Description : Passive checker on a ping-pong counter output. Each count_clk
//               edge the current out/direction is checked against the previous
//               sample and the previous controls, classified as step, bounce,
//               flip or hold, and any illegal transition latches a sticky
//               first-error code.
// Ports       : count_clk, filtered_rst (async, active-high), ctr_rst_n,
//               enable, max, min, out, direction in;
//               synced, step_p, bounce_p, flip_p, hold_p, bounce_cnt,
//               flip_cnt, err, err_code out.
// Config      : PPM_EVENT_CNT_EN - when defined, bounce_cnt/flip_cnt are
//               saturating counters; otherwise both are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ping_pong_monitor
    import ppm_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             count_clk,
    input  logic             filtered_rst,
    input  logic             ctr_rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] out,
    input  logic             direction,
    output logic             synced,
    output logic             step_p,
    output logic             bounce_p,
    output logic             flip_p,
    output logic             hold_p,
    output logic [CNT_W-1:0] bounce_cnt,
    output logic [CNT_W-1:0] flip_cnt,
    output logic             err,
    output logic [1:0]       err_code
);

    ppm_state_t       r_state;
    ppm_state_t       w_next_state;
    ppm_event_t       w_event;
    logic [1:0]       w_err_code_new;
    logic             w_err_hit;

    logic [WIDTH-1:0] r_prev_out;
    logic             r_prev_dir;
    logic             r_prev_en;
    logic [WIDTH-1:0] r_prev_max;
    logic [WIDTH-1:0] r_prev_min;

    logic [WIDTH:0]   w_nrm_val;
    logic             w_nrm_dir;
    logic [WIDTH:0]   w_flip_val;
    logic             w_flip_dir;
    logic             w_hold;
    logic             w_at_bound;
    logic             w_inside;
    logic [WIDTH:0]   w_out_ext;

    logic             r_synced;
    logic             r_step_p;
    logic             r_bounce_p;
    logic             r_flip_p;
    logic             r_hold_p;
    logic             r_err;
    logic [1:0]       r_err_code;

    assign w_out_ext = {1'b0, out};

    ppm_next_calc #(
        .WIDTH (WIDTH)
    ) u_next_calc (
        .i_prev_out (r_prev_out),
        .i_prev_dir (r_prev_dir),
        .i_prev_en  (r_prev_en),
        .i_prev_max (r_prev_max),
        .i_prev_min (r_prev_min),
        .o_nrm_val  (w_nrm_val),
        .o_nrm_dir  (w_nrm_dir),
        .o_flip_val (w_flip_val),
        .o_flip_dir (w_flip_dir),
        .o_hold     (w_hold),
        .o_at_bound (w_at_bound),
        .o_inside   (w_inside)
    );

    // ---------------- state register ----------------
    always_ff @(posedge count_clk or posedge filtered_rst) begin
        if (filtered_rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        if (!ctr_rst_n) begin
            w_next_state = S_INIT;
        end else begin
            case (r_state)
                S_INIT:  w_next_state = S_TRACK;
                S_TRACK: w_next_state = w_err_hit ? S_ERR : S_TRACK;
                S_ERR:   w_next_state = S_ERR;
                default: w_next_state = S_INIT;
            endcase
        end
    end

    // ---------------- output / classification logic ----------------
    // Only a tracking edge with the counter out of reset is classified, so a
    // re-sync edge never reports an event or latches an error.
    always_comb begin
        w_event        = EV_NONE;
        w_err_code_new = ERR_NONE;
        if (ctr_rst_n && (r_state == S_TRACK)) begin
            if (w_hold) begin
                if ((out == r_prev_out) && (direction == r_prev_dir)) begin
                    w_event = EV_HOLD;
                end else begin
                    w_err_code_new = ERR_STEP;
                end
            end else if ((out < r_prev_min) || (out > r_prev_max)) begin
                w_err_code_new = ERR_RANGE;
            end else if ((w_out_ext == w_nrm_val) && (direction == w_nrm_dir)) begin
                // A flip at a bound produces the same value as a bounce.
                w_event = w_at_bound ? EV_BOUNCE : EV_STEP;
            end else if (w_inside && (w_out_ext == w_flip_val) &&
                         (direction == w_flip_dir)) begin
                w_event = EV_FLIP;
            end else if ((w_out_ext == w_nrm_val) ||
                         (w_inside && (w_out_ext == w_flip_val))) begin
                w_err_code_new = ERR_DIR;
            end else begin
                w_err_code_new = ERR_STEP;
            end
        end
    end

    assign w_err_hit = (w_err_code_new != ERR_NONE);

    // ---------------- previous-sample capture ----------------
    always_ff @(posedge count_clk or posedge filtered_rst) begin
        if (filtered_rst) begin
            r_prev_out <= '0;
            r_prev_dir <= 1'b0;
            r_prev_en  <= 1'b0;
            r_prev_max <= '0;
            r_prev_min <= '0;
        end else if (ctr_rst_n && (r_state != S_ERR)) begin
            r_prev_out <= out;
            r_prev_dir <= direction;
            r_prev_en  <= enable;
            r_prev_max <= max;
            r_prev_min <= min;
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge count_clk or posedge filtered_rst) begin
        if (filtered_rst) begin
            r_synced   <= 1'b0;
            r_step_p   <= 1'b0;
            r_bounce_p <= 1'b0;
            r_flip_p   <= 1'b0;
            r_hold_p   <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_step_p   <= (w_event == EV_STEP);
            r_bounce_p <= (w_event == EV_BOUNCE);
            r_flip_p   <= (w_event == EV_FLIP);
            r_hold_p   <= (w_event == EV_HOLD);
            if (!ctr_rst_n) begin
                r_synced   <= 1'b0;
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
            end else begin
                r_synced <= (r_state != S_INIT);
                // Errors are only raised while tracking, and tracking ends on
                // the first one, so this always records the first error.
                if (w_err_hit) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_err_code_new;
                end
            end
        end
    end

    assign synced   = r_synced;
    assign step_p   = r_step_p;
    assign bounce_p = r_bounce_p;
    assign flip_p   = r_flip_p;
    assign hold_p   = r_hold_p;
    assign err      = r_err;
    assign err_code = r_err_code;

    // ---------------- optional event counters ----------------
`ifdef PPM_EVENT_CNT_EN
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [CNT_W-1:0] r_bounce_cnt;
    logic [CNT_W-1:0] r_flip_cnt;

    always_ff @(posedge count_clk or posedge filtered_rst) begin
        if (filtered_rst) begin
            r_bounce_cnt <= '0;
            r_flip_cnt   <= '0;
        end else begin
            if ((w_event == EV_BOUNCE) && (r_bounce_cnt != '1)) begin
                r_bounce_cnt <= r_bounce_cnt + c_cnt_one;
            end
            if ((w_event == EV_FLIP) && (r_flip_cnt != '1)) begin
                r_flip_cnt <= r_flip_cnt + c_cnt_one;
            end
        end
    end

    assign bounce_cnt = r_bounce_cnt;
    assign flip_cnt   = r_flip_cnt;
`else
    assign bounce_cnt = '0;
    assign flip_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ping_pong_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ping_pong_monitor
// Description : Self-checking bench for ping_pong_monitor. A generator walks a
//               ping-pong counter (with injected flips, corruptions, enable
//               drops, bound changes and counter resets) and a rule-level
//               reference model predicts every monitor output per edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ping_pong_monitor;

    localparam int WIDTH   = 4;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int VMAX    = (1 << WIDTH) - 1;

    // model event classes
    localparam int C_STEP   = 1;
    localparam int C_BOUNCE = 2;
    localparam int C_FLIP   = 3;
    localparam int C_HOLD   = 4;
    localparam int C_ESTEP  = 5;
    localparam int C_ERANGE = 6;
    localparam int C_EDIR   = 7;

    logic             count_clk = 1'b0;
    logic             filtered_rst;
    logic             ctr_rst_n;
    logic             enable;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    logic [WIDTH-1:0] out;
    logic             direction;
    logic             synced;
    logic             step_p;
    logic             bounce_p;
    logic             flip_p;
    logic             hold_p;
    logic [CNT_W-1:0] bounce_cnt;
    logic [CNT_W-1:0] flip_cnt;
    logic             err;
    logic [1:0]       err_code;

    ping_pong_monitor #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .count_clk    (count_clk),
        .filtered_rst (filtered_rst),
        .ctr_rst_n    (ctr_rst_n),
        .enable       (enable),
        .max          (max),
        .min          (min),
        .out          (out),
        .direction    (direction),
        .synced       (synced),
        .step_p       (step_p),
        .bounce_p     (bounce_p),
        .flip_p       (flip_p),
        .hold_p       (hold_p),
        .bounce_cnt   (bounce_cnt),
        .flip_cnt     (flip_cnt),
        .err          (err),
        .err_code     (err_code)
    );

    always #5 count_clk = ~count_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_mode;                 // 0 no previous sample, 1 checking, 2 error
    int m_synced, m_step, m_bounce, m_flip, m_hold, m_err, m_code, m_bcnt, m_fcnt;
    int pv_o, pv_d, pv_en, pv_mx, pv_mn;

    // last sample driven (generator memory)
    int g_o, g_d, g_en, g_mx, g_mn;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void successors(input int p, input int d, input int en,
                                       input int mx, input int mn,
                                       output int hold, output int nv, output int nd,
                                       output int ncls, output int fok,
                                       output int fv, output int fd);
        hold = (en == 0 || mx <= mn || p < mn || p > mx) ? 1 : 0;
        if (d != 0) begin
            if (p < mx) begin nv = p + 1; nd = 1; ncls = C_STEP;   end
            else        begin nv = p - 1; nd = 0; ncls = C_BOUNCE; end
        end else begin
            if (p > mn) begin nv = p - 1; nd = 0; ncls = C_STEP;   end
            else        begin nv = p + 1; nd = 1; ncls = C_BOUNCE; end
        end
        fok = (p > mn && p < mx) ? 1 : 0;
        fv  = (d != 0) ? p - 1 : p + 1;
        fd  = (d != 0) ? 0 : 1;
    endfunction

    function automatic int classify(input int p, input int d, input int en,
                                    input int mx, input int mn,
                                    input int o, input int c);
        int hold, nv, nd, ncls, fok, fv, fd;
        successors(p, d, en, mx, mn, hold, nv, nd, ncls, fok, fv, fd);
        if (hold != 0)                              return (o == p && c == d) ? C_HOLD : C_ESTEP;
        if (o < mn || o > mx)                       return C_ERANGE;
        if (o == nv && c == nd)                     return ncls;
        if (fok != 0 && o == fv && c == fd)         return C_FLIP;
        if (o == nv || (fok != 0 && o == fv))       return C_EDIR;
        return C_ESTEP;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_synced = 0; m_step = 0; m_bounce = 0; m_flip = 0; m_hold = 0;
        m_err = 0; m_code = 0; m_bcnt = 0; m_fcnt = 0;
        pv_o = 0; pv_d = 0; pv_en = 0; pv_mx = 0; pv_mn = 0;
    endtask

    task automatic model_edge(input int rn, input int en, input int mx, input int mn,
                              input int o, input int c);
        int cls;
        m_step = 0; m_bounce = 0; m_flip = 0; m_hold = 0;
        if (rn == 0) begin
            m_mode = 0; m_synced = 0; m_err = 0; m_code = 0;
        end else if (m_mode == 0) begin
            pv_o = o; pv_d = c; pv_en = en; pv_mx = mx; pv_mn = mn;
            m_mode = 1; m_synced = 0;
        end else if (m_mode == 1) begin
            m_synced = 1;
            cls = classify(pv_o, pv_d, pv_en, pv_mx, pv_mn, o, c);
            case (cls)
                C_STEP:   m_step = 1;
                C_BOUNCE: begin m_bounce = 1; if (m_bcnt < CNT_MAX) m_bcnt++; end
                C_FLIP:   begin m_flip = 1;   if (m_fcnt < CNT_MAX) m_fcnt++; end
                C_HOLD:   m_hold = 1;
                C_ESTEP:  begin m_err = 1; m_code = 1; m_mode = 2; end
                C_ERANGE: begin m_err = 1; m_code = 2; m_mode = 2; end
                default:  begin m_err = 1; m_code = 3; m_mode = 2; end
            endcase
            pv_o = o; pv_d = c; pv_en = en; pv_mx = mx; pv_mn = mn;
        end else begin
            m_synced = 1;
        end
    endtask

    task automatic check_outputs();
        int eb, ef;
`ifdef PPM_EVENT_CNT_EN
        eb = m_bcnt; ef = m_fcnt;
`else
        eb = 0; ef = 0;
`endif
        check_val("synced",     int'(synced),     m_synced);
        check_val("step_p",     int'(step_p),     m_step);
        check_val("bounce_p",   int'(bounce_p),   m_bounce);
        check_val("flip_p",     int'(flip_p),     m_flip);
        check_val("hold_p",     int'(hold_p),     m_hold);
        check_val("err",        int'(err),        m_err);
        check_val("err_code",   int'(err_code),   m_code);
        check_val("bounce_cnt", int'(bounce_cnt), eb);
        check_val("flip_cnt",   int'(flip_cnt),   ef);
    endtask

    // Drive one sample, let it be taken at the next edge, then compare.
    task automatic apply(input int rn, input int en, input int mx, input int mn,
                         input int o, input int c);
        ctr_rst_n = (rn != 0);
        enable    = (en != 0);
        max       = WIDTH'(mx);
        min       = WIDTH'(mn);
        out       = WIDTH'(o);
        direction = (c != 0);
        @(posedge count_clk);
        model_edge(rn, en, mx, mn, o, c);
        #1;
        check_outputs();
        g_o = o; g_d = c; g_en = en; g_mx = mx; g_mn = mn;
    endtask

    // Next counter sample from the previous one: legal move, optional flip,
    // optional random corruption (percentages).
    task automatic gen_step(input int rn, input int en, input int mx, input int mn,
                            input int flip_pct, input int bad_pct);
        int hold, nv, nd, ncls, fok, fv, fd, o, c;
        successors(g_o, g_d, g_en, g_mx, g_mn, hold, nv, nd, ncls, fok, fv, fd);
        if (hold != 0) begin o = g_o; c = g_d; end
        else begin o = nv; c = nd; end
        if (hold == 0 && fok != 0 && $urandom_range(0, 99) < flip_pct) begin
            o = fv; c = fd;
        end
        if ($urandom_range(0, 99) < bad_pct) begin
            o = $urandom_range(0, VMAX);
            c = $urandom_range(0, 1);
        end
        if (o < 0 || o > VMAX) o = g_o;
        apply(rn, en, mx, mn, o, c);
    endtask

    task automatic async_reset_check();
        #2 filtered_rst = 1'b1;
        #1;
        model_reset();
        check_val("arst_synced",   int'(synced),   0);
        check_val("arst_pulses",   int'({step_p, bounce_p, flip_p, hold_p}), 0);
        check_val("arst_err",      int'(err),      0);
        check_val("arst_err_code", int'(err_code), 0);
        check_val("arst_counts",   int'({bounce_cnt, flip_cnt}), 0);
        #1 filtered_rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur_mx, cur_mn, rn, en;
        filtered_rst = 1'b1;
        ctr_rst_n = 1'b1; enable = 1'b0; max = '0; min = '0; out = '0; direction = 1'b0;
        g_o = 0; g_d = 0; g_en = 0; g_mx = 0; g_mn = 0;
        model_reset();
        repeat (3) @(posedge count_clk);
        #1;
        check_outputs();
        filtered_rst = 1'b0;

        // Plain ping-pong over [2,5]: 20 samples, six bounces.
        apply(1, 1, 5, 2, 2, 1);
        repeat (19) gen_step(1, 1, 5, 2, 0, 0);

        // Flip at 3 while counting up: 3 -> 2 down.
        for (int i = 0; i < 12 && !(g_o == 3 && g_d == 1); i++) gen_step(1, 1, 5, 2, 0, 0);
        apply(1, 1, 5, 2, 2, 0);
        repeat (3) gen_step(1, 1, 5, 2, 0, 0);

        // Enable dropped: first edge still uses the enabled controls, then holds.
        repeat (5) gen_step(1, 0, 5, 2, 0, 0);
        repeat (3) gen_step(1, 1, 5, 2, 0, 0);

        // Illegal jump 4 -> 2, pulses suppressed afterwards, re-sync clears.
        for (int i = 0; i < 12 && g_o != 4; i++) gen_step(1, 1, 5, 2, 0, 0);
        apply(1, 1, 5, 2, 2, g_d);
        repeat (3) gen_step(1, 1, 5, 2, 0, 0);
        gen_step(0, 1, 5, 2, 0, 0);

        // Out of range, then a second bad value keeps the first code.
        repeat (4) gen_step(1, 1, 5, 2, 0, 0);
        apply(1, 1, 5, 2, 7, 1);
        apply(1, 1, 5, 2, 6, 0);
        gen_step(0, 1, 5, 2, 0, 0);

        // Bounds at the ends of the value range.
        apply(1, 1, VMAX, 0, VMAX - 2, 1);
        repeat (40) gen_step(1, 1, VMAX, 0, 10, 0);

        // Randomized run.
        cur_mx = 5; cur_mn = 2;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 99) < 4) begin
                cur_mx = $urandom_range(0, VMAX);
                cur_mn = $urandom_range(0, VMAX);
            end
            rn = ($urandom_range(0, 99) < 3) ? 0 : 1;
            en = ($urandom_range(0, 99) < 10) ? 0 : 1;
            gen_step(rn, en, cur_mx, cur_mn, 15, 4);
            if (k == 1200 || k == 2000) begin
                async_reset_check();
                gen_step(1, 1, cur_mx, cur_mn, 0, 0);
                gen_step(1, 1, cur_mx, cur_mn, 0, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
